// File: rtl/mem_pkg.sv
// Shared encodings for the memory request path: access sizes, arbiter states and the
// size-to-byte-count mapping used by mem_external.
package mem_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'b00,
      ARB_BUSY    = 2'b01,
      ARB_RELEASE = 2'b10
   } arb_state_e;

   // The reserved size encoding is treated as a full word.
   function automatic logic [2:0] size_to_num_bytes(input logic [1:0] size);
      logic [2:0] n;
      case (size)
         SIZE_BYTE: n = 3'd1;
         SIZE_HALF: n = 3'd2;
         default:   n = 3'd4;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/load_formatter.sv
// Right-justifies left-justified short read data from mem_external and extends it
// to 32 bits; bits below the valid bytes never reach the result.
module load_formatter
   import mem_pkg::*;
(
   input  logic [31:0] mem_rdata,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] result
);

   always_comb begin
      result = mem_rdata;
      case (size)
         SIZE_BYTE: result = {{24{~is_unsigned & mem_rdata[31]}}, mem_rdata[31:24]};
         SIZE_HALF: result = {{16{~is_unsigned & mem_rdata[31]}}, mem_rdata[31:16]};
         default:   result = mem_rdata;
      endcase
   end

endmodule

// File: rtl/mem_request_arbiter.sv
// Grants fetch or load/store requests one at a time onto mem_external's level-held
// start/done handshake and returns formatted read data to the granted requester.
module mem_request_arbiter
   import mem_pkg::*;
#(
   parameter bit LS_PRIORITY = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_req,
   input  logic [31:0] fetch_addr,
   output logic        fetch_done,
   output logic [31:0] fetch_data,
   input  logic        ls_req,
   input  logic        ls_write,
   input  logic [31:0] ls_addr,
   input  logic [1:0]  ls_size,
   input  logic        ls_unsigned,
   input  logic [31:0] ls_wdata,
   output logic        ls_done,
   output logic [31:0] ls_rdata,
   output logic        mem_start,
   output logic [2:0]  mem_num_bytes,
   output logic [31:0] mem_addr,
   output logic        mem_is_write,
   output logic [31:0] mem_wdata,
   input  logic        mem_done,
   input  logic [31:0] mem_rdata
);

   arb_state_e  state_q, state_d;
   logic [31:0] addr_q, wdata_q;
   logic [1:0]  size_q;
   logic        write_q, unsigned_q, src_ls_q;
   logic        fetch_done_q, ls_done_q;
   logic [31:0] fetch_data_q, ls_rdata_q;
   logic        grant_ls, grant_fetch, capture;
   logic [31:0] fmt_data;

   load_formatter u_load_formatter (
      .mem_rdata   (mem_rdata),
      .size        (size_q),
      .is_unsigned (unsigned_q),
      .result      (fmt_data)
   );

   always_comb begin
      state_d     = state_q;
      grant_ls    = 1'b0;
      grant_fetch = 1'b0;
      capture     = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (ls_req && (!fetch_req || LS_PRIORITY)) begin
               grant_ls = 1'b1;
            end else if (fetch_req) begin
               grant_fetch = 1'b1;
            end
            if (grant_ls || grant_fetch) state_d = ARB_BUSY;
         end
         ARB_BUSY: begin
            if (mem_done) begin
               capture = 1'b1;
               state_d = ARB_RELEASE;
            end
         end
         // One cycle with start low lets mem_external return to its start state.
         ARB_RELEASE: state_d = ARB_IDLE;
         default:     state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ARB_IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         size_q       <= '0;
         write_q      <= 1'b0;
         unsigned_q   <= 1'b0;
         src_ls_q     <= 1'b0;
         fetch_done_q <= 1'b0;
         ls_done_q    <= 1'b0;
         fetch_data_q <= '0;
         ls_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         fetch_done_q <= capture && !src_ls_q;
         ls_done_q    <= capture && src_ls_q;
         if (grant_ls) begin
            addr_q     <= ls_addr;
            wdata_q    <= ls_wdata;
            size_q     <= ls_size;
            write_q    <= ls_write;
            unsigned_q <= ls_unsigned;
            src_ls_q   <= 1'b1;
         end else if (grant_fetch) begin
            addr_q     <= fetch_addr;
            wdata_q    <= '0;
            size_q     <= SIZE_WORD;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            src_ls_q   <= 1'b0;
         end
         if (capture && !src_ls_q) fetch_data_q <= fmt_data;
         if (capture && src_ls_q && !write_q) ls_rdata_q <= fmt_data;
      end
   end

   assign mem_start     = (state_q == ARB_BUSY);
   assign mem_num_bytes = size_to_num_bytes(size_q);
   assign mem_addr      = addr_q;
   assign mem_is_write  = write_q;
   assign mem_wdata     = wdata_q;
   assign fetch_done    = fetch_done_q;
   assign fetch_data    = fetch_data_q;
   assign ls_done       = ls_done_q;
   assign ls_rdata      = ls_rdata_q;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed bench for mem_request_arbiter: table of single transactions plus
// hand-written priority, reset-abort and stray-done sequences.
module tb_mem_request_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_req = 1'b0;
   logic [31:0] fetch_addr = '0;
   logic        fetch_done;
   logic [31:0] fetch_data;
   logic        ls_req = 1'b0;
   logic        ls_write = 1'b0;
   logic [31:0] ls_addr = '0;
   logic [1:0]  ls_size = '0;
   logic        ls_unsigned = 1'b0;
   logic [31:0] ls_wdata = '0;
   logic        ls_done;
   logic [31:0] ls_rdata;
   logic        mem_start;
   logic [2:0]  mem_num_bytes;
   logic [31:0] mem_addr;
   logic        mem_is_write;
   logic [31:0] mem_wdata;
   logic        mem_done = 1'b0;
   logic [31:0] mem_rdata = '0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_request_arbiter #(.LS_PRIORITY(1'b1)) dut (
      .clk           (clk),
      .rst           (rst),
      .fetch_req     (fetch_req),
      .fetch_addr    (fetch_addr),
      .fetch_done    (fetch_done),
      .fetch_data    (fetch_data),
      .ls_req        (ls_req),
      .ls_write      (ls_write),
      .ls_addr       (ls_addr),
      .ls_size       (ls_size),
      .ls_unsigned   (ls_unsigned),
      .ls_wdata      (ls_wdata),
      .ls_done       (ls_done),
      .ls_rdata      (ls_rdata),
      .mem_start     (mem_start),
      .mem_num_bytes (mem_num_bytes),
      .mem_addr      (mem_addr),
      .mem_is_write  (mem_is_write),
      .mem_wdata     (mem_wdata),
      .mem_done      (mem_done),
      .mem_rdata     (mem_rdata)
   );

   typedef struct {
      bit          is_fetch;
      bit          write;
      logic [1:0]  size;
      bit          uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [2:0]  exp_nb;
      logic [31:0] exp_res;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      @(negedge clk);
      if (v.is_fetch) begin
         fetch_req  = 1'b1;
         fetch_addr = v.addr;
      end else begin
         ls_req      = 1'b1;
         ls_write    = v.write;
         ls_addr     = v.addr;
         ls_size     = v.size;
         ls_unsigned = v.uns;
         ls_wdata    = v.wdata;
      end
      @(negedge clk);
      chk("grant_start", 32'(mem_start), 32'd1);
      chk("num_bytes", 32'(mem_num_bytes), 32'(v.exp_nb));
      chk("addr", mem_addr, v.addr);
      chk("is_write", 32'(mem_is_write), 32'(v.write));
      if (v.write) chk("wdata", mem_wdata, v.wdata);
      // Scramble requester inputs; the latched transaction must not move.
      fetch_addr = 32'hFFFF_FFFF;
      ls_addr    = 32'hFFFF_FFFF;
      ls_size    = 2'b00;
      ls_wdata   = 32'h0;
      @(negedge clk);
      @(negedge clk);
      chk("busy_addr", mem_addr, v.addr);
      chk("busy_nb", 32'(mem_num_bytes), 32'(v.exp_nb));
      chk("busy_start", 32'(mem_start), 32'd1);
      mem_done  = 1'b1;
      mem_rdata = v.rdata;
      @(negedge clk);
      chk("release_start", 32'(mem_start), 32'd0);
      chk("fetch_done_pulse", 32'(fetch_done), 32'(v.is_fetch));
      chk("ls_done_pulse", 32'(ls_done), 32'(!v.is_fetch));
      if (v.is_fetch) chk("fetch_data", fetch_data, v.exp_res);
      else            chk("ls_rdata", ls_rdata, v.exp_res);
      mem_done  = 1'b0;
      mem_rdata = 32'h5A5A_5A5A;
      fetch_req = 1'b0;
      ls_req    = 1'b0;
      @(negedge clk);
      chk("done_drop", 32'({fetch_done, ls_done}), 32'd0);
   endtask

   initial begin
      //         fetch wr  size   uns addr          wdata         rdata         nb    result
      tbl[0] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 32'h4433_2211, 3'd4, 32'h4433_2211};
      tbl[1] = '{1'b0, 1'b0, 2'b00, 1'b0, 32'h0100_0003, 32'h0, 32'h80AB_CDEF, 3'd1, 32'hFFFF_FF80};
      tbl[2] = '{1'b0, 1'b0, 2'b00, 1'b1, 32'h0100_0003, 32'h0, 32'h8012_3456, 3'd1, 32'h0000_0080};
      tbl[3] = '{1'b0, 1'b0, 2'b01, 1'b0, 32'h0000_0020, 32'h0, 32'hF234_5678, 3'd2, 32'hFFFF_F234};
      tbl[4] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 32'h1234_5678, 3'd2,
                 32'hFFFF_F234};
      tbl[5] = '{1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'hCAFE_BABE, 3'd4, 32'hCAFE_BABE};
      tbl[6] = '{1'b0, 1'b0, 2'b11, 1'b0, 32'h0000_0104, 32'h0, 32'h8000_0001, 3'd4, 32'h8000_0001};
      tbl[7] = '{1'b0, 1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'h0, 32'h8001_FFFF, 3'd2, 32'h0000_8001};
      tbl[8] = '{1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0301, 32'h0, 32'h7F00_0000, 3'd1, 32'h0000_007F};

      repeat (2) @(negedge clk);
      chk("rst_start", 32'(mem_start), 32'd0);
      chk("rst_dones", 32'({fetch_done, ls_done}), 32'd0);
      chk("rst_fetch_data", fetch_data, 32'h0);
      chk("rst_ls_rdata", ls_rdata, 32'h0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) run_vec(tbl[i]);

      // Simultaneous requests: load/store first, fetch two cycles after ls_done.
      @(negedge clk);
      fetch_req   = 1'b1;
      fetch_addr  = 32'h0000_0400;
      ls_req      = 1'b1;
      ls_write    = 1'b0;
      ls_addr     = 32'h0000_0300;
      ls_size     = 2'b10;
      ls_unsigned = 1'b0;
      @(negedge clk);
      chk("prio_start", 32'(mem_start), 32'd1);
      chk("prio_addr_ls", mem_addr, 32'h0000_0300);
      @(negedge clk);
      mem_done  = 1'b1;
      mem_rdata = 32'h1111_2222;
      @(negedge clk);
      chk("prio_ls_done", 32'({fetch_done, ls_done}), 32'd1);
      chk("prio_ls_rdata", ls_rdata, 32'h1111_2222);
      chk("prio_gap1", 32'(mem_start), 32'd0);
      mem_done = 1'b0;
      ls_req   = 1'b0;
      @(negedge clk);
      chk("prio_gap2", 32'(mem_start), 32'd0);
      @(negedge clk);
      chk("prio_fetch_start", 32'(mem_start), 32'd1);
      chk("prio_fetch_addr", mem_addr, 32'h0000_0400);
      chk("prio_fetch_nb", 32'(mem_num_bytes), 32'd4);
      mem_done  = 1'b1;
      mem_rdata = 32'h3333_4444;
      @(negedge clk);
      chk("prio_fetch_done", 32'({fetch_done, ls_done}), 32'd2);
      chk("prio_fetch_data", fetch_data, 32'h3333_4444);
      mem_done  = 1'b0;
      fetch_req = 1'b0;

      // mem_done while idle must be ignored.
      @(negedge clk);
      mem_done = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_done_start", 32'(mem_start), 32'd0);
      chk("idle_done_pulses", 32'({fetch_done, ls_done}), 32'd0);
      mem_done = 1'b0;

      // Reset in the middle of a transaction aborts it without a done pulse.
      @(negedge clk);
      ls_req   = 1'b1;
      ls_write = 1'b0;
      ls_addr  = 32'h0000_0500;
      ls_size  = 2'b10;
      @(negedge clk);
      chk("abort_busy", 32'(mem_start), 32'd1);
      rst = 1'b1;
      #1;
      chk("abort_start_now", 32'(mem_start), 32'd0);
      mem_done  = 1'b1;
      mem_rdata = 32'h9999_9999;
      @(negedge clk);
      chk("abort_no_done", 32'({fetch_done, ls_done}), 32'd0);
      chk("abort_ls_rdata", ls_rdata, 32'h0);
      chk("abort_fetch_data", fetch_data, 32'h0);
      rst      = 1'b0;
      mem_done = 1'b0;
      ls_req   = 1'b0;
      @(negedge clk);
      chk("abort_idle", 32'(mem_start), 32'd0);
      run_vec(tbl[1]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
